// File: rtl/and_32_pkg.sv
// Shared ALU definitions: datapath width and the big-endian word type
// used by the 32-bit logic units.
package and_32_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef logic [0:ALU_WIDTH-1] alu_word_t;

endpackage : and_32_pkg

// File: rtl/and_32_and_1.sv
// Single-bit two-input AND cell; replicated across the word by and_32.
module and_1 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a & b;

endmodule : and_1

// File: rtl/and_32.sv
// Bitwise AND unit: combinational result Z plus a one-cycle registered copy
// with a valid pulse and zero flag for pipelined consumers.
module and_32
    import and_32_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:WIDTH-1] X,
    input  logic [0:WIDTH-1] Y,
    input  logic             in_valid,
    output logic [0:WIDTH-1] Z,
    output logic [0:WIDTH-1] Z_q,
    output logic             out_valid,
    output logic             zero_q
);

    logic [0:WIDTH-1] res_d;
    logic [0:WIDTH-1] res_q;
    logic             zero_d;
    logic             zero_flag_q;
    logic             valid_d;
    logic             valid_q;

    // One AND cell per bit; Z stays zero-latency and independent of clk/rst_n.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        and_1 u_and_1 (
            .a (X[i]),
            .b (Y[i]),
            .y (Z[i])
        );
    end

    // Capture on in_valid; otherwise hold data and drop the valid pulse.
    always_comb begin
        res_d   = res_q;
        zero_d  = zero_flag_q;
        valid_d = 1'b0;
        if (in_valid) begin
            res_d   = Z;
            zero_d  = ~|Z;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q       <= '0;
            zero_flag_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            res_q       <= res_d;
            zero_flag_q <= zero_d;
            valid_q     <= valid_d;
        end
    end

    assign Z_q       = res_q;
    assign zero_q    = zero_flag_q;
    assign out_valid = valid_q;

endmodule : and_32

// File: tb/tb_and_32.sv
// Directed self-checking bench for and_32: combinational checks plus a
// scoreboard of expected registered outputs popped after each clock edge.
module tb_and_32;
    import and_32_pkg::*;

    typedef struct {
        alu_word_t zq;
        logic      zero;
        logic      vld;
    } exp_t;

    logic      clk;
    logic      rst_n;
    logic      in_valid;
    alu_word_t X;
    alu_word_t Y;
    alu_word_t Z;
    alu_word_t Z_q;
    logic      out_valid;
    logic      zero_q;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    exp_t      sb[$];
    alu_word_t m_zq;
    logic      m_zero;

    and_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (X),
        .Y         (Y),
        .in_valid  (in_valid),
        .Z         (Z),
        .Z_q       (Z_q),
        .out_valid (out_valid),
        .zero_q    (zero_q)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [0:31] obs, input logic [0:31] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle at the falling edge, predict the registered state,
    // then compare against the scoreboard just after the rising edge.
    task automatic cycle(input string tag, input logic rst, input logic iv,
                         input alu_word_t x, input alu_word_t y);
        exp_t e;
        @(negedge clk);
        rst_n    = rst;
        in_valid = iv;
        X        = x;
        Y        = y;
        if (!rst) begin
            m_zq   = '0;
            m_zero = 1'b0;
            e.vld  = 1'b0;
        end else if (iv) begin
            m_zq   = x & y;
            m_zero = (m_zq == '0);
            e.vld  = 1'b1;
        end else begin
            e.vld  = 1'b0;
        end
        e.zq   = m_zq;
        e.zero = m_zero;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_zq"},    Z_q,            e.zq);
            chk({tag, "_zero"},  32'(zero_q),    32'(e.zero));
            chk({tag, "_valid"}, 32'(out_valid), 32'(e.vld));
        end
        chk({tag, "_z"}, Z, x & y);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        m_zq     = '0;
        m_zero   = 1'b0;

        // Combinational path, before the first clock edge.
        X = 32'hAAFF12FF; Y = 32'hFF00FF00; #1;
        chk("comb0", Z, 32'hAA001200);
        X = 32'hFF0000FF; Y = 32'hFF00FF00; #1;
        chk("comb1", Z, 32'hFF000000);
        X = 32'h00FF00FF; Y = 32'hFF00FF00; #1;
        chk("comb2", Z, 32'h00000000);
        X = 32'h0F0F0F0F; Y = 32'hFFFFFFFF; #1;
        chk("comb3", Z, 32'h0F0F0F0F);
        X = 32'h0F0F0F0F; Y = 32'h00000000; #1;
        chk("comb4", Z, 32'h00000000);

        // Reset wins over in_valid; Z keeps tracking.
        cycle("rst0", 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        cycle("rst1", 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("rst_zq_lit", Z_q, 32'h00000000);
        chk("rst_z_lit",  Z,   32'hFFFFFFFF);

        // Back-to-back captures.
        cycle("pipe0", 1'b1, 1'b1, 32'hAAFF12FF, 32'hFF00FF00);
        chk("pipe0_lit", Z_q, 32'hAA001200);
        cycle("pipe1", 1'b1, 1'b1, 32'h00FF00FF, 32'hFF00FF00);
        chk("pipe1_zero_lit", 32'(zero_q), 32'd1);

        // Hold with changing inputs.
        cycle("hold0", 1'b1, 1'b0, 32'h12345678, 32'hFFFF0000);
        cycle("hold1", 1'b1, 1'b0, 32'hDEADBEEF, 32'hFFFFFFFF);
        cycle("hold2", 1'b1, 1'b0, 32'h0000FFFF, 32'h00FF00FF);
        chk("hold_zq_lit", Z_q, 32'h00000000);

        // Nonzero capture, a hold, then reset mid-stream.
        cycle("cap0",  1'b1, 1'b1, 32'hDEADBEEF, 32'hF0F0F0F0);
        chk("cap0_lit", Z_q, 32'hD0A0B0E0);
        cycle("hold3", 1'b1, 1'b0, 32'h00000000, 32'h00000000);
        cycle("mrst",  1'b0, 1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF);
        cycle("cap1",  1'b1, 1'b1, 32'h80000001, 32'hFFFFFFFF);

        // Bit ordering: bit 0 is the MSB.
        @(negedge clk);
        in_valid = 1'b0;
        X = 32'h80000000; Y = 32'h80000000; #1;
        chk("bit0",      32'(Z[0]), 32'd1);
        chk("bit0_word", Z,         32'h80000000);
        X = 32'h00000001; Y = 32'h00000001; #1;
        chk("bit31",      32'(Z[31]), 32'd1);
        chk("bit31_word", Z,          32'h00000001);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_and_32
